// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches between GShare lookup and GShare update.
// Pops on resolve, emits a registered update strobe and flushes younger entries on mispredict.
module branch_resolve_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   predictValid,
  input  logic [PC_W-1:0]        predictPc,
  input  logic                   prediction,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   resolveValid,
  input  logic                   resolveTaken,
  output logic                   update,
  output logic [PC_W-1:0]        updatePc,
  output logic                   reality,
  output logic                   mispredict
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             update_q, update_d;
  logic [PC_W-1:0]  update_pc_q, update_pc_d;
  logic             reality_q, reality_d;
  logic             mispredict_q, mispredict_d;

  logic [PC_W-1:0]  pc_mem   [DEPTH];
  logic             pred_mem [DEPTH];

  logic push_ok;
  logic pop_ok;
  logic flush;
  logic wr_en;

  // Fullness/emptiness are judged on the count at the start of the cycle.
  always_comb begin
    push_ok      = predictValid && (count_q != CNT_W'(DEPTH));
    pop_ok       = resolveValid && (count_q != '0);
    flush        = pop_ok && (resolveTaken != pred_mem[head_q]);
    wr_en        = push_ok && !flush;

    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    update_d     = pop_ok;
    mispredict_d = flush;
    update_pc_d  = update_pc_q;
    reality_d    = reality_q;

    if (pop_ok) begin
      head_d      = head_q + PTR_W'(1);
      update_pc_d = pc_mem[head_q];
      reality_d   = resolveTaken;
    end

    // A mispredict discards every younger entry, including a same-cycle push.
    if (flush) begin
      tail_d  = head_q + PTR_W'(1);
      count_d = '0;
    end else begin
      if (push_ok) begin
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      update_q     <= 1'b0;
      update_pc_q  <= '0;
      reality_q    <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      update_q     <= update_d;
      update_pc_q  <= update_pc_d;
      reality_q    <= reality_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[tail_q]   <= predictPc;
      pred_mem[tail_q] <= prediction;
    end
  end

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign update     = update_q;
  assign updatePc   = update_pc_q;
  assign reality    = reality_q;
  assign mispredict = mispredict_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_branch_resolve_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;

  logic            clk;
  logic            reset;
  logic            predictValid;
  logic [PC_W-1:0] predictPc;
  logic            prediction;
  logic            full;
  logic            empty;
  logic [2:0]      count;
  logic            resolveValid;
  logic            resolveTaken;
  logic            update;
  logic [PC_W-1:0] updatePc;
  logic            reality;
  logic            mispredict;

  int tests = 0;
  int fails = 0;

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset),
    .predictValid(predictValid), .predictPc(predictPc), .prediction(prediction),
    .full(full), .empty(empty), .count(count),
    .resolveValid(resolveValid), .resolveTaken(resolveTaken),
    .update(update), .updatePc(updatePc), .reality(reality), .mispredict(mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, pred} entries.
  typedef struct {
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  ent_t        mq[$];
  logic        m_update;
  logic [31:0] m_pc;
  logic        m_real;
  logic        m_mis;
  bit          model_ok = 0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_update = 1'b0;
      m_pc     = '0;
      m_real   = 1'b0;
      m_mis    = 1'b0;
      model_ok = 1;
    end else begin
      bit   do_push;
      bit   do_pop;
      ent_t e;
      do_push  = predictValid && (mq.size() < DEPTH);
      do_pop   = resolveValid && (mq.size() > 0);
      m_update = do_pop;
      m_mis    = 1'b0;
      if (do_pop) begin
        e      = mq.pop_front();
        m_pc   = e.pc;
        m_real = resolveTaken;
        m_mis  = (e.pred != resolveTaken);
        if (m_mis) mq.delete();
      end
      if (do_push && !m_mis) begin
        e.pc   = predictPc;
        e.pred = prediction;
        mq.push_back(e);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("count",      32'(count),      32'(mq.size()));
      check("empty",      32'(empty),      32'(mq.size() == 0));
      check("full",       32'(full),       32'(mq.size() == DEPTH));
      check("update",     32'(update),     32'(m_update));
      check("mispredict", 32'(mispredict), 32'(m_mis));
      check("updatePc",   updatePc,        m_pc);
      check("reality",    32'(reality),    32'(m_real));
    end
  end

  task automatic drive(input bit pv, input logic [31:0] pc, input bit pr,
                       input bit rv, input bit rt);
    predictValid = pv;
    predictPc    = pc;
    prediction   = pr;
    resolveValid = rv;
    resolveTaken = rt;
    @(posedge clk);
    #1;
    predictValid = 1'b0;
    resolveValid = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input bit pr);
    drive(1'b1, pc, pr, 1'b0, 1'b0);
  endtask

  task automatic pop(input bit rt);
    drive(1'b0, 32'h0, 1'b0, 1'b1, rt);
  endtask

  initial begin
    reset = 1'b1;
    predictValid = 1'b0;
    predictPc = '0;
    prediction = 1'b0;
    resolveValid = 1'b0;
    resolveTaken = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst_count",  32'(count),  32'd0);
    check("rst_empty",  32'(empty),  32'd1);
    check("rst_full",   32'(full),   32'd0);
    check("rst_update", 32'(update), 32'd0);
    check("rst_mis",    32'(mispredict), 32'd0);
    check("rst_pc",     updatePc,    32'h0);

    // In-order push/pop with correct predictions
    push(32'h10, 1'b1);
    push(32'h20, 1'b0);
    push(32'h30, 1'b1);
    check("inord_count", 32'(count), 32'd3);
    pop(1'b1);
    check("inord_upd0", 32'(update), 32'd1);
    check("inord_pc0",  updatePc,    32'h10);
    check("inord_re0",  32'(reality), 32'd1);
    pop(1'b0);
    check("inord_pc1",  updatePc,    32'h20);
    check("inord_re1",  32'(reality), 32'd0);
    check("inord_mis1", 32'(mispredict), 32'd0);
    pop(1'b1);
    check("inord_pc2",  updatePc,    32'h30);
    check("inord_cnt",  32'(count),  32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("inord_idle", 32'(update), 32'd0);
    check("inord_hold", updatePc,    32'h30);

    // Full and overflow
    for (int i = 0; i < 5; i++) begin
      push(32'h100 + 32'(i) * 32'h10, 1'b0);
      if (i == 3) check("ovf_full", 32'(full), 32'd1);
    end
    check("ovf_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      pop(1'b0);
      check("ovf_pc", updatePc, 32'h100 + 32'(i) * 32'h10);
    end
    pop(1'b0);
    check("ovf_empty_pop", 32'(update), 32'd0);
    check("ovf_empty",     32'(empty),  32'd1);

    // Mispredict flush with a same-cycle wrong-path push
    push(32'h40, 1'b1);
    push(32'h44, 1'b1);
    push(32'h48, 1'b1);
    drive(1'b1, 32'h4C, 1'b1, 1'b1, 1'b0);
    check("mis_upd",   32'(update),     32'd1);
    check("mis_pc",    updatePc,        32'h40);
    check("mis_real",  32'(reality),    32'd0);
    check("mis_flag",  32'(mispredict), 32'd1);
    check("mis_count", 32'(count),      32'd0);
    check("mis_empty", 32'(empty),      32'd1);
    pop(1'b1);
    check("mis_nostore", 32'(update), 32'd0);

    // Wrap-around with simultaneous push/pop, two outstanding
    push(32'h200, 1'b0);
    push(32'h204, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h200 + 32'(i + 2) * 32'h4, 1'((i + 2) % 2), 1'b1, 1'(i % 2));
      check("wrap_pc",    updatePc,        32'h200 + 32'(i) * 32'h4);
      check("wrap_count", 32'(count),      32'd2);
      check("wrap_mis",   32'(mispredict), 32'd0);
    end
    pop(1'b0);
    check("wrap_drain0", updatePc, 32'h228);
    pop(1'b1);
    check("wrap_drain1", updatePc, 32'h22C);

    // Reset mid-operation alongside a resolve
    push(32'h300, 1'b1);
    push(32'h304, 1'b1);
    push(32'h308, 1'b1);
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    reset = 1'b0;
    check("mrst_upd",   32'(update), 32'd0);
    check("mrst_count", 32'(count),  32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("mrst_upd2",  32'(update), 32'd0);
    pop(1'b1);
    check("mrst_pop",   32'(update), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Push while empty with an ignored pop in the same cycle
    drive(1'b1, 32'h400, 1'b1, 1'b1, 1'b1);
    check("emp_pp_upd",   32'(update), 32'd0);
    check("emp_pp_count", 32'(count),  32'd1);
    pop(1'b1);
    check("emp_pp_pc",    updatePc,    32'h400);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
